// File: rtl/prio_req_dispatch.sv
// Sticky request capture with per-line masking, highest-index-first selection
// and a valid/ready dispatch port feeding the 8-to-3 priority encoder path.
module prio_req_dispatch #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         mask_wr,
  input  logic [N-1:0] mask_din,
  input  logic         ovf_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic [N-1:0] mask,
  output logic         none,
  output logic         ovf
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       r_state;
  logic [N-1:0] r_pend;
  logic [N-1:0] r_mask;
  logic         r_ovf;
  logic         r_valid;
  logic [W-1:0] r_idx;

  logic         w_handshake;
  logic [N-1:0] w_clrVec;
  logic [N-1:0] w_cand;
  logic         w_anyCand;
  logic [W-1:0] w_selIdx;

  assign w_handshake = r_valid & out_ready;
  assign w_clrVec    = w_handshake ? (N'(1) << r_idx) : '0;
  assign w_cand      = r_pend & ~r_mask;
  assign w_anyCand   = |w_cand;

  // Ascending scan so the last (highest) set line wins, matching the encoder.
  always_comb begin
    w_selIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_selIdx = W'(i);
    end
  end

  // A request landing on a bit being cleared re-arms it without flagging overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clrVec) | req;
      if (|(req & r_pend & ~w_clrVec)) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (mask_wr) begin
        r_mask <= mask_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && w_anyCand) begin
            r_idx   <= w_selIdx;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign pend      = r_pend;
  assign mask      = r_mask;
  assign ovf       = r_ovf;
  assign none      = en & ~w_anyCand & ~r_valid;

endmodule

// File: tb/tb_prio_req_dispatch.sv
// Scoreboard bench for prio_req_dispatch: a set-based reference model predicts
// each dispatch offer, and a negedge monitor checks offers and visible state.
module tb_prio_req_dispatch;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] req;
  logic         mask_wr;
  logic [N-1:0] mask_din;
  logic         ovf_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pend;
  logic [N-1:0] mask;
  logic         none;
  logic         ovf;

  prio_req_dispatch #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .mask_wr(mask_wr), .mask_din(mask_din), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .pend(pend), .mask(mask), .none(none), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  bit started = 1'b0;

  // Reference model state: a set of pending lines, mask set, and the current offer.
  bit   mPend [N];
  bit   mMask [N];
  bit   mOvf   = 1'b0;
  bit   mValid = 1'b0;
  int   mIdx   = 0;
  int   expQ[$];
  int   hsLog[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] packSet(input bit s [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = s[i];
    return v;
  endfunction

  function automatic int highestCandidate();
    for (int i = N - 1; i >= 0; i--) begin
      if (mPend[i] && !mMask[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic modelEdge();
    bit hs;
    bit ovfHit;
    int pick;
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mPend[i] = 1'b0;
        mMask[i] = 1'b0;
      end
      mOvf = 1'b0;
      mValid = 1'b0;
      mIdx = 0;
      expQ.delete();
      return;
    end
    hs = mValid && out_ready;
    pick = (!mValid && en) ? highestCandidate() : -1;
    ovfHit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && mPend[i] && !(hs && i == mIdx)) ovfHit = 1'b1;
    end
    if (ovfHit) mOvf = 1'b1;
    else if (ovf_clr) mOvf = 1'b0;
    if (hs) mPend[mIdx] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) mPend[i] = 1'b1;
      if (mask_wr) mMask[i] = mask_din[i];
    end
    if (hs) begin
      mValid = 1'b0;
    end else if (pick >= 0) begin
      mValid = 1'b1;
      mIdx = pick;
      expQ.push_back(pick);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic e, input logic rdy,
                               input logic mw, input logic [N-1:0] md, input logic oc,
                               input logic rs, input int cycles);
    req = r; en = e; out_ready = rdy; mask_wr = mw; mask_din = md; ovf_clr = oc; rst = rs;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelEdge();
      #1;
      req = '0; mask_wr = 1'b0; ovf_clr = 1'b0;
    end
  endtask

  // Monitor: inputs are stable by the falling edge, so the upcoming handshake is visible.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("pend", pend, packSet(mPend));
      checkOutput("mask", mask, packSet(mMask));
      checkOutput("ovf", ovf, mOvf);
      checkOutput("out_valid", out_valid, mValid);
      checkOutput("none", none, en && highestCandidate() < 0 && !mValid);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOffer", out_idx, 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_idx", out_idx, expQ[0]);
          if (out_ready && !rst) begin
            hsLog.push_back(expQ.pop_front());
          end
        end
      end
    end
  end

  task automatic checkLog(input string name, input int exp [$]);
    checkOutput({name, "_count"}, hsLog.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checkOutput(name, (i < hsLog.size()) ? hsLog[i] : -1, exp[i]);
    end
    hsLog.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mPend[i] = 1'b0;
      mMask[i] = 1'b0;
    end
    req = '0; en = 1'b0; out_ready = 1'b0; mask_wr = 1'b0; mask_din = '0; ovf_clr = 1'b0;
    rst = 1'b1;

    // Reset then idle
    applyStimulus('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 2);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2);
    checkOutput("idleValid", out_valid, 1'b0);
    checkOutput("idleNone", none, 1'b1);
    checkOutput("idlePend", pend, 8'h00);

    // Priority order
    applyStimulus(8'h26, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 10);
    checkLog("prioOrder", '{5, 2, 1});
    checkOutput("prioPendEmpty", pend, 8'h00);

    // Backpressure with a new request arriving mid-hold
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2);
    applyStimulus(8'h08, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3);
    checkOutput("holdIdx", out_idx, 7);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 10);
    checkLog("backpressure", '{7, 3, 0});

    // Mask and enable
    applyStimulus('0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1);
    applyStimulus(8'h81, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 2);
    checkOutput("maskPend", pend, 8'h81);
    checkOutput("maskNoValid", out_valid, 1'b0);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 6);
    checkLog("maskedDispatch", '{0});
    checkOutput("maskedLeft", pend, 8'h80);
    applyStimulus('0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 6);
    checkLog("unmaskDispatch", '{7});

    // Overflow is sticky until cleared
    applyStimulus(8'h10, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus(8'h10, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 3);
    checkOutput("ovfSticky", ovf, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1);
    checkOutput("ovfCleared", ovf, 1'b0);

    // Set wins over the handshake clear on the same line
    applyStimulus('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2);
    applyStimulus(8'h10, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    checkOutput("setWinsPend", pend, 8'h10);
    checkOutput("setWinsOvf", ovf, 1'b0);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 6);
    checkLog("setWins", '{4, 4});

    // Reset during an outstanding offer
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2);
    checkOutput("preRstValid", out_valid, 1'b1);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1);
    checkOutput("rstValid", out_valid, 1'b0);
    checkOutput("rstPend", pend, 8'h00);
    checkOutput("rstMask", mask, 8'h00);
    applyStimulus(8'h02, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 4);
    checkLog("postRst", '{1});

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      applyStimulus(N'($urandom & $urandom & $urandom),
                    ($urandom_range(3) != 0), $urandom_range(1) == 1,
                    ($urandom_range(7) == 0), N'($urandom & $urandom),
                    ($urandom_range(7) == 0), ($urandom_range(63) == 0), 1);
    end
    hsLog.delete();

    // Drain everything that is still pending
    applyStimulus('0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 40);
    checkOutput("drainPend", pend, 8'h00);
    checkOutput("drainQueue", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
